// File: rtl/dil_stream_pkg.sv
// Shared constants for the Dilithium result streamer: word counts, mode codes, section ids and section order.
// Latency: none (package: constants and constant functions only).
// Backpressure: not applicable.
// Contents: DIL_W / DIL_SEC_LEVEL defaults, *_SIZE (bytes) and *_WORDS_NUM, mode encodings, sec_id_t,
//           per-mode section-order tables (sec_at / kind_at / num_secs) and the sec_last word-count helper.
package dil_stream_pkg;

   localparam int DIL_W         = 64;
   localparam int DIL_SEC_LEVEL = 2;

   localparam logic [1:0] KEYGEN_MODE = 2'b00;
   localparam logic [1:0] SIGN_MODE   = 2'b10;
   localparam logic [1:0] VERIFY_MODE = 2'b01;

   // Ids 6 and 7 are shared: t1/z and c/h, depending on the mode.
   typedef enum logic [2:0] {
      SEC_RHO = 3'd0, SEC_KEY = 3'd1, SEC_TR = 3'd2, SEC_S1 = 3'd3,
      SEC_S2  = 3'd4, SEC_T0  = 3'd5, SEC_T1Z = 3'd6, SEC_CH = 3'd7
   } sec_id_t;

   typedef enum logic [2:0] {SZ_SEED, SZ_T1, SZ_S1, SZ_S2, SZ_T0, SZ_Z, SZ_H} size_kind_t;

   function automatic int dil_k(input int lvl);
      return (lvl == 2) ? 4 : (lvl == 3) ? 6 : 8;
   endfunction

   function automatic int dil_l(input int lvl);
      return (lvl == 2) ? 4 : (lvl == 3) ? 5 : 7;
   endfunction

   // Packed-polynomial byte counts: eta=4 only at level 3, gamma1=2^17 only at level 2.
   function automatic int eta_poly_bytes(input int lvl);
      return (lvl == 3) ? 128 : 96;
   endfunction

   function automatic int z_poly_bytes(input int lvl);
      return (lvl == 2) ? 576 : 640;
   endfunction

   function automatic int dil_omega(input int lvl);
      return (lvl == 2) ? 80 : (lvl == 3) ? 55 : 75;
   endfunction

   function automatic int size_bytes(input size_kind_t kind, input int lvl);
      case (kind)
         SZ_SEED: return 32;
         SZ_T1:   return 320 * dil_k(lvl);
         SZ_S1:   return eta_poly_bytes(lvl) * dil_l(lvl);
         SZ_S2:   return eta_poly_bytes(lvl) * dil_k(lvl);
         SZ_T0:   return 416 * dil_k(lvl);
         SZ_Z:    return z_poly_bytes(lvl) * dil_l(lvl);
         default: return dil_omega(lvl) + dil_k(lvl);
      endcase
   endfunction

   function automatic int words_num(input int bytes, input int w);
      return (bytes * 8 + w - 1) / w;
   endfunction

   localparam int SEED_SIZE      = size_bytes(SZ_SEED, DIL_SEC_LEVEL);
   localparam int T1_SIZE        = size_bytes(SZ_T1, DIL_SEC_LEVEL);
   localparam int S1_SIZE        = size_bytes(SZ_S1, DIL_SEC_LEVEL);
   localparam int S2_SIZE        = size_bytes(SZ_S2, DIL_SEC_LEVEL);
   localparam int T0_SIZE        = size_bytes(SZ_T0, DIL_SEC_LEVEL);
   localparam int Z_SIZE         = size_bytes(SZ_Z, DIL_SEC_LEVEL);
   localparam int H_SIZE         = size_bytes(SZ_H, DIL_SEC_LEVEL);
   localparam int SEED_WORDS_NUM = words_num(SEED_SIZE, DIL_W);
   localparam int T1_WORDS_NUM   = words_num(T1_SIZE, DIL_W);
   localparam int S1_WORDS_NUM   = words_num(S1_SIZE, DIL_W);
   localparam int S2_WORDS_NUM   = words_num(S2_SIZE, DIL_W);
   localparam int T0_WORDS_NUM   = words_num(T0_SIZE, DIL_W);
   localparam int Z_WORDS_NUM    = words_num(Z_SIZE, DIL_W);
   localparam int H_WORDS_NUM    = words_num(H_SIZE, DIL_W);

   function automatic int num_secs(input logic [1:0] mode);
      return (mode == KEYGEN_MODE) ? 7 : (mode == SIGN_MODE) ? 3 : 0;
   endfunction

   // Keygen: rho, t1, key, tr, s1, s2, t0.  Sign: c, z, h.
   function automatic sec_id_t sec_at(input logic [1:0] mode, input logic [2:0] idx);
      sec_id_t s;
      s = SEC_RHO;
      if (mode == SIGN_MODE) begin
         s = (idx == 3'd1) ? SEC_T1Z : SEC_CH;
      end else begin
         case (idx)
            3'd0:    s = SEC_RHO;
            3'd1:    s = SEC_T1Z;
            3'd2:    s = SEC_KEY;
            3'd3:    s = SEC_TR;
            3'd4:    s = SEC_S1;
            3'd5:    s = SEC_S2;
            default: s = SEC_T0;
         endcase
      end
      return s;
   endfunction

   function automatic size_kind_t kind_at(input logic [1:0] mode, input logic [2:0] idx);
      size_kind_t k;
      k = SZ_SEED;
      if (mode == SIGN_MODE) begin
         k = (idx == 3'd0) ? SZ_SEED : (idx == 3'd1) ? SZ_Z : SZ_H;
      end else begin
         case (idx)
            3'd1:    k = SZ_T1;
            3'd4:    k = SZ_S1;
            3'd5:    k = SZ_S2;
            3'd6:    k = SZ_T0;
            default: k = SZ_SEED;
         endcase
      end
      return k;
   endfunction

   // Index of the last word of a section; 0 for slots the mode does not use.
   function automatic int sec_last(input logic [1:0] mode, input logic [2:0] idx,
                                   input int lvl, input int w);
      if (int'(idx) >= num_secs(mode)) return 0;
      return words_num(size_bytes(kind_at(mode, idx), lvl), w) - 1;
   endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; head is presented combinationally from storage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: clk, rst (sync, active high), push/push_dat, pop, head_dat (oldest entry), cnt (0..2).
module sync_fifo2 #(
   parameter int DW = 65
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_dat,
   input  logic          pop,
   output logic [DW-1:0] head_dat,
   output logic [1:0]    cnt
);

   logic [DW-1:0] mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop   = pop && (cnt != 2'd0);
   assign do_push  = push && ((cnt != 2'd2) || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/sig_word_tx.sv
// Streams one Dilithium result set (keygen/sign sections, or the verify verdict) as W-bit words with a last flag.
// Latency: first rd_en 1 cycle after start, first out_valid 3 cycles after start; 1 word/cycle sustained.
// Backpressure: reads are throttled so returned words always fit the 2-entry buffer; nothing is dropped.
// Ports: clk/rst; start, mode, verify_ok (sampled with start); busy, done, err status;
//        rd_en/rd_sec/rd_addr -> rd_data (1-cycle read port); out_data/out_valid/out_last/out_ready stream.
module sig_word_tx
   import dil_stream_pkg::*;
#(
   parameter int W         = DIL_W,
   parameter int SEC_LEVEL = DIL_SEC_LEVEL,
   parameter int ADDR_W    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              verify_ok,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              rd_en,
   output logic [2:0]        rd_sec,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [W-1:0]      rd_data,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READ, ST_DRAIN} state_t;

   localparam int KG_LAST [8] = '{
      sec_last(KEYGEN_MODE, 3'd0, SEC_LEVEL, W), sec_last(KEYGEN_MODE, 3'd1, SEC_LEVEL, W),
      sec_last(KEYGEN_MODE, 3'd2, SEC_LEVEL, W), sec_last(KEYGEN_MODE, 3'd3, SEC_LEVEL, W),
      sec_last(KEYGEN_MODE, 3'd4, SEC_LEVEL, W), sec_last(KEYGEN_MODE, 3'd5, SEC_LEVEL, W),
      sec_last(KEYGEN_MODE, 3'd6, SEC_LEVEL, W), sec_last(KEYGEN_MODE, 3'd7, SEC_LEVEL, W)};
   localparam int SG_LAST [8] = '{
      sec_last(SIGN_MODE, 3'd0, SEC_LEVEL, W), sec_last(SIGN_MODE, 3'd1, SEC_LEVEL, W),
      sec_last(SIGN_MODE, 3'd2, SEC_LEVEL, W), sec_last(SIGN_MODE, 3'd3, SEC_LEVEL, W),
      sec_last(SIGN_MODE, 3'd4, SEC_LEVEL, W), sec_last(SIGN_MODE, 3'd5, SEC_LEVEL, W),
      sec_last(SIGN_MODE, 3'd6, SEC_LEVEL, W), sec_last(SIGN_MODE, 3'd7, SEC_LEVEL, W)};
   localparam logic [2:0] KG_LAST_SEC = 3'(num_secs(KEYGEN_MODE) - 1);
   localparam logic [2:0] SG_LAST_SEC = 3'(num_secs(SIGN_MODE) - 1);

   state_t            state, state_n;
   logic [1:0]        mode_q;
   logic              vok_q;
   logic [2:0]        sec_idx, sec_idx_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic              inflight;
   logic              last_inflight;
   logic              done_q;
   logic              err_q;

   logic              issue;
   logic              final_rd;
   logic              push_vrf;
   logic              push;
   logic [W:0]        push_dat;
   logic              pop;
   logic              final_pop;
   logic [W:0]        head_dat;
   logic [1:0]        fifo_cnt;
   logic [1:0]        room_use;
   logic [ADDR_W-1:0] last_addr;
   logic [2:0]        last_sec;

   assign out_valid = (fifo_cnt != 2'd0);
   assign pop       = out_valid && out_ready;
   assign final_pop = pop && head_dat[W];
   assign out_data  = out_valid ? head_dat[W-1:0] : '0;
   assign out_last  = out_valid && head_dat[W];

   // Slots that will be taken next cycle, counting this cycle's pop as already freed;
   // a read issued now lands next cycle, so it needs this to stay below 2.
   assign room_use  = fifo_cnt - {1'b0, pop} + {1'b0, inflight};

   assign last_addr = (mode_q == SIGN_MODE) ? ADDR_W'(SG_LAST[sec_idx]) : ADDR_W'(KG_LAST[sec_idx]);
   assign last_sec  = (mode_q == SIGN_MODE) ? SG_LAST_SEC : KG_LAST_SEC;

   always_comb begin
      state_n   = state;
      sec_idx_n = sec_idx;
      addr_n    = addr;
      issue     = 1'b0;
      final_rd  = 1'b0;
      push_vrf  = 1'b0;
      case (state)
         ST_IDLE: begin
            sec_idx_n = 3'd0;
            addr_n    = '0;
            if (start && (mode != 2'b11)) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            if (mode_q == VERIFY_MODE) begin
               push_vrf = 1'b1;
               state_n  = ST_DRAIN;
            end else begin
               issue   = (room_use < 2'd2);
               state_n = ST_READ;
            end
         end
         ST_READ:  issue = (room_use < 2'd2);
         ST_DRAIN: if (final_pop) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
      if (issue) begin
         if (addr == last_addr) begin
            addr_n = '0;
            if (sec_idx == last_sec) begin
               final_rd = 1'b1;
               state_n  = ST_DRAIN;
            end else begin
               sec_idx_n = sec_idx + 3'd1;
            end
         end else begin
            addr_n = addr + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         mode_q        <= KEYGEN_MODE;
         vok_q         <= 1'b0;
         sec_idx       <= 3'd0;
         addr          <= '0;
         inflight      <= 1'b0;
         last_inflight <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state         <= state_n;
         sec_idx       <= sec_idx_n;
         addr          <= addr_n;
         inflight      <= issue;
         last_inflight <= final_rd;
         done_q        <= (state == ST_DRAIN) && final_pop;
         err_q         <= (state == ST_IDLE) && start && (mode == 2'b11);
         if ((state == ST_IDLE) && start && (mode != 2'b11)) begin
            mode_q <= mode;
            vok_q  <= verify_ok;
         end
      end
   end

   // Returned read data carries the last tag decided at issue; the verdict word is pushed directly.
   assign push     = inflight || push_vrf;
   assign push_dat = inflight ? {last_inflight, rd_data} : {1'b1, {(W-1){1'b0}}, vok_q};

   sync_fifo2 #(.DW(W + 1)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .cnt      (fifo_cnt)
   );

   assign busy    = (state != ST_IDLE);
   assign done    = done_q;
   assign err     = err_q;
   assign rd_en   = issue;
   assign rd_sec  = issue ? 3'(sec_at(mode_q, sec_idx)) : 3'd0;
   assign rd_addr = issue ? addr : '0;

endmodule

// File: tb/tb_sig_word_tx.sv
// Scoreboard bench for sig_word_tx at level 2, W=64: expected words queued at start, popped on each handshake.
// Latency: checks first rd_en / first out_valid timing and done one cycle after the final handshake.
// Backpressure: out_ready driven always-high, random, or held low to exercise the 2-entry buffer.
module tb_sig_word_tx;

   localparam int W      = 64;
   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        mode;
   logic              verify_ok;
   logic              busy, done, err, rd_en;
   logic [2:0]        rd_sec;
   logic [ADDR_W-1:0] rd_addr;
   logic [W-1:0]      rd_data;
   logic [W-1:0]      out_data;
   logic              out_valid, out_last, out_ready;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          hs_cnt, rd_cnt, done_cnt, last_cyc, done_cyc;
   int          ready_pol = 0;
   logic [64:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [64:0] prev_word;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Result buffer model: each word encodes {section id, word index}.
   always @(posedge clk) rd_data <= rd_en ? {52'd0, rd_sec, rd_addr} : 64'hdead_beef_0bad_f00d;

   sig_word_tx #(.W(W), .SEC_LEVEL(2), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .verify_ok (verify_ok),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rd_en     (rd_en),
      .rd_sec    (rd_sec),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // Monitor: sets out_ready for the coming edge, then checks handshakes and hold stability.
   always @(negedge clk) begin : mon
      logic [64:0] w;
      case (ready_pol)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
      #1;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_val("hold_valid", 65'(out_valid), 65'd1);
            check_val("hold_word", {out_last, out_data}, prev_word);
         end
         if (rd_en) rd_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               check_val("q_underflow", 65'(exp_q.size()), 65'd1);
            end else begin
               w = exp_q.pop_front();
               check_val($sformatf("word%0d", hs_cnt - 1), {out_last, out_data}, w);
               if (w[64]) last_cyc = cyc;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_word  = {out_last, out_data};
      end
   end

   task automatic build_exp(input logic [1:0] m, input logic vok);
      int secs [7];
      int lens [7];
      int ns;
      if (m == 2'b10) begin
         ns = 3; secs = '{7, 6, 7, 0, 0, 0, 0}; lens = '{4, 288, 11, 0, 0, 0, 0};
      end else begin
         ns = 7; secs = '{0, 6, 1, 2, 3, 4, 5}; lens = '{4, 160, 4, 4, 48, 48, 208};
      end
      if (m == 2'b01) exp_q.push_back({1'b1, 63'd0, vok});
      else
         for (int s = 0; s < ns; s++)
            for (int a = 0; a < lens[s]; a++)
               exp_q.push_back({(s == ns - 1 && a == lens[s] - 1), 52'd0, 3'(secs[s]), 9'(a)});
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_busy"}, 65'(busy), 65'd0);
      check_val({tag, "_done"}, 65'(done), 65'd0);
      check_val({tag, "_err"}, 65'(err), 65'd0);
      check_val({tag, "_rden"}, 65'(rd_en), 65'd0);
      check_val({tag, "_vld"}, 65'(out_valid), 65'd0);
      check_val({tag, "_last"}, 65'(out_last), 65'd0);
      check_val({tag, "_data"}, 65'(out_data), 65'd0);
   endtask

   task automatic run_op(input logic [1:0] m, input logic vok, input int n_words, input int n_reads,
                         input int stall_at, input int busy_at, input int rst_at, input string tag);
      bit stalled = 1'b0;
      bit busied  = 1'b0;
      int snap;
      int bound;
      build_exp(m, vok);
      hs_cnt = 0; rd_cnt = 0; done_cnt = 0; last_cyc = -10; done_cyc = -20;
      start = 1'b1; mode = m; verify_ok = vok;
      tick();
      start = 1'b0; mode = 2'b00; verify_ok = ~vok;
      check_val({tag, "_busy1"}, 65'(busy), 65'd1);
      check_val({tag, "_rden1"}, 65'(rd_en), 65'(m != 2'b01));
      if (m != 2'b01) begin
         tick();
         check_val({tag, "_vld2"}, 65'(out_valid), 65'd0);
         tick();
         check_val({tag, "_vld3"}, 65'(out_valid), 65'd1);
      end
      bound = 0;
      while (done_cnt == 0 && bound < 3000) begin
         if (rst_at >= 0 && hs_cnt >= rst_at) begin
            rst = 1'b1;
            tick();
            check_idle_outputs({tag, "_rst"});
            rst = 1'b0;
            repeat (10) tick();
            check_val({tag, "_no_done"}, 65'(done_cnt), 65'd0);
            check_val({tag, "_idle"}, 65'(busy), 65'd0);
            exp_q.delete();
            return;
         end
         if (stall_at >= 0 && !stalled && hs_cnt >= stall_at) begin
            stalled   = 1'b1;
            ready_pol = 2;
            snap      = rd_cnt;
            repeat (20) tick();
            check_val({tag, "_stall_rd"}, 65'((rd_cnt - snap) <= 2), 65'd1);
            check_val({tag, "_stall_vld"}, 65'(out_valid), 65'd1);
            ready_pol = 0;
         end else if (busy_at >= 0 && !busied && hs_cnt >= busy_at) begin
            busied = 1'b1;
            start = 1'b1; mode = 2'b01; verify_ok = 1'b1;
            tick();
            start = 1'b0;
         end else begin
            tick();
         end
         bound++;
      end
      check_val({tag, "_done"}, 65'(done_cnt), 65'd1);
      check_val({tag, "_busy_end"}, 65'(busy), 65'd0);
      tick();
      check_val({tag, "_done_pulse"}, 65'(done), 65'd0);
      check_val({tag, "_done_once"}, 65'(done_cnt), 65'd1);
      check_val({tag, "_done_lat"}, 65'(done_cyc - last_cyc), 65'd1);
      check_val({tag, "_words"}, 65'(hs_cnt), 65'(n_words));
      check_val({tag, "_reads"}, 65'(rd_cnt), 65'(n_reads));
      check_val({tag, "_q_empty"}, 65'(exp_q.size()), 65'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'b00; verify_ok = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      run_op(2'b10, 1'b0, 303, 303, -1, 50, -1, "sign");
      ready_pol = 1;
      run_op(2'b00, 1'b0, 476, 476, -1, -1, -1, "keygen");
      ready_pol = 0;
      run_op(2'b01, 1'b1, 1, 0, -1, -1, -1, "vrf1");
      run_op(2'b01, 1'b0, 1, 0, -1, -1, -1, "vrf0");
      run_op(2'b10, 1'b0, 303, 303, 4 + 50, -1, -1, "stall");

      start = 1'b1; mode = 2'b11;
      tick();
      start = 1'b0;
      check_val("bad_mode_err", 65'(err), 65'd1);
      check_val("bad_mode_busy", 65'(busy), 65'd0);
      tick();
      check_val("bad_mode_err_clr", 65'(err), 65'd0);
      check_val("bad_mode_idle", 65'(busy), 65'd0);
      check_val("bad_mode_rden", 65'(rd_en), 65'd0);

      run_op(2'b10, 1'b0, 0, 0, -1, -1, 4 + 100, "rstmid");
      run_op(2'b10, 1'b0, 303, 303, -1, -1, -1, "resign");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
